// File: rtl/axilregs_pkg.sv
// Shared register layouts, receiver state encoding and word-length decode
// used by the UART receive path.
package axilregs_pkg;

  typedef struct packed {
    logic [7:0] rsvd;
    logic       rxneie;
    logic       te;
    logic       ps;
    logic       pce;
    logic [1:0] wl;
    logic       re;
    logic       aue;
  } cr1_reg_t;

  typedef struct packed {
    logic [11:0] mantissa;
    logic [3:0]  fraction;
  } brr_reg_t;

  typedef struct packed {
    logic idlecf;
    logic orecf;
    logic fecf;
    logic pecf;
  } icr_reg_t;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam logic [1:0] WL_8     = 2'b00;
  localparam logic [1:0] WL_9     = 2'b01;
  localparam logic [1:0] WL_7     = 2'b10;
  localparam logic [1:0] WL_8_ALT = 2'b11;

  function automatic logic [3:0] wl_bits(input logic [1:0] wl);
    case (wl)
      WL_8:     return 4'd8;
      WL_9:     return 4'd9;
      WL_7:     return 4'd7;
      WL_8_ALT: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional oversample tick generator: a tick every mantissa clocks, one
// clock longer whenever the 4-bit fraction accumulator carries.
module uart_baud_gen
  import axilregs_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  brr_reg_t brr,
  input  logic     enable,
  input  logic     restart,
  output logic     tick
);

  logic [11:0] cnt;
  logic [3:0]  acc;
  logic [4:0]  acc_sum;
  logic [12:0] period;

  // The carry of the pending accumulation stretches the current period.
  assign acc_sum = {1'b0, acc} + {1'b0, brr.fraction};
  assign period  = {1'b0, brr.mantissa} + {12'd0, acc_sum[4]};
  assign tick    = enable && !restart && (brr.mantissa != '0) &&
                   ({1'b0, cnt} >= period - 13'd1);

  always_ff @(posedge clk) begin
    if (!rst_n || restart || !enable) begin
      cnt <= '0;
      acc <= '0;
    end else if (tick) begin
      cnt <= '0;
      acc <= acc_sum[3:0];
    end else if (brr.mantissa != '0) begin
      cnt <= cnt + 12'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver with majority-vote sampling, optional parity,
// single-word holding register and sticky status flags.
module uart_rx
  import axilregs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  cr1_reg_t   cr1,
  input  brr_reg_t   brr,
  input  icr_reg_t   icr,
  input  logic       rxd,
  output logic [8:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       pe,
  output logic       fe,
  output logic       ore,
  output logic       idle,
  output logic       busy
);

  rx_state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync;
  logic       rxs, rxs_d, fall, en, restart, tick, mid, bend, maj, s7, s8;
  logic [3:0] tcnt, bitcnt, nbits;
  logic [8:0] word;
  logic       par;
  logic [7:0] idle_cnt;
  logic       idle_arm;
  logic       commit, take, pe_set, fe_set, ore_set, idle_set;
  logic       unused_cr1;

  assign unused_cr1 = ^{cr1.rsvd, cr1.rxneie, cr1.te};

  assign en      = cr1.aue & cr1.re;
  assign rxs     = sync[SYNC_STAGES-1];
  assign fall    = rxs_d & ~rxs;
  assign restart = en && (state == IDLE) && fall;
  assign nbits   = wl_bits(cr1.wl);
  assign mid     = tick && (tcnt == 4'd9);
  assign bend    = tick && (tcnt == 4'd15);
  assign maj     = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign busy    = (state != IDLE);

  uart_baud_gen u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .brr     (brr),
    .enable  (en),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    pe_set   = 1'b0;
    fe_set   = 1'b0;
    if (!en || brr.mantissa == '0) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (fall) state_nx = START;
        START: begin
          if (mid && maj)  state_nx = IDLE;
          else if (bend)   state_nx = DATA;
        end
        DATA:  if (bend && bitcnt == nbits - 4'd1) state_nx = cr1.pce ? PARITY : STOP;
        PARITY: begin
          pe_set = mid && (par ^ maj ^ cr1.ps);
          if (bend) state_nx = STOP;
        end
        STOP: begin
          if (mid) begin
            commit   = 1'b1;
            fe_set   = ~maj;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync   <= '1;
      rxs_d  <= 1'b1;
      tcnt   <= '0;
      bitcnt <= '0;
      word   <= '0;
      par    <= 1'b0;
      s7     <= 1'b1;
      s8     <= 1'b1;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], rxd};
      rxs_d <= rxs;
      if (restart) begin
        tcnt   <= '0;
        bitcnt <= '0;
        word   <= '0;
        par    <= 1'b0;
      end else if (tick && state != IDLE) begin
        tcnt <= tcnt + 4'd1;
        if (tcnt == 4'd7) s7 <= rxs;
        if (tcnt == 4'd8) s8 <= rxs;
        if (state == DATA && tcnt == 4'd9) begin
          word[bitcnt] <= maj;
          par          <= par ^ maj;
        end
        if (state == DATA && tcnt == 4'd15) bitcnt <= bitcnt + 4'd1;
      end
    end
  end

  assign take     = commit && (!rx_valid || rx_ready);
  assign ore_set  = commit && rx_valid && !rx_ready;
  // The 160th high tick in IDLE marks ten full bit periods of quiet line.
  assign idle_set = idle_arm && (state == IDLE) && rxs && tick && (idle_cnt == 8'd159);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      pe       <= 1'b0;
      fe       <= 1'b0;
      ore      <= 1'b0;
      idle     <= 1'b0;
      idle_cnt <= '0;
      idle_arm <= 1'b0;
    end else begin
      if (take) begin
        rx_data  <= word;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      pe   <= (pe   & ~icr.pecf)   | pe_set;
      fe   <= (fe   & ~icr.fecf)   | fe_set;
      ore  <= (ore  & ~icr.orecf)  | ore_set;
      idle <= (idle & ~icr.idlecf) | idle_set;
      if (state != IDLE || !rxs)             idle_cnt <= '0;
      else if (tick && idle_cnt != 8'd160)   idle_cnt <= idle_cnt + 8'd1;
      if (commit)        idle_arm <= 1'b1;
      else if (idle_set) idle_arm <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed frame stimulus for uart_rx, checked against a
// frame-level model of the receiver's expected word and flags.
module tb_uart_rx;
  import axilregs_pkg::*;

  logic       clk, rst_n, rxd, rx_ready;
  cr1_reg_t   cr1;
  brr_reg_t   brr;
  icr_reg_t   icr;
  logic [8:0] rx_data;
  logic       rx_valid, pe, fe, ore, idle, busy;

  int unsigned bitclk;
  int unsigned nchecks, npass;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cr1(cr1), .brr(brr), .icr(icr), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pe(pe), .fe(fe), .ore(ore), .idle(idle), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int unsigned nbits_of(input logic [1:0] wl);
    return (wl == 2'b01) ? 9 : (wl == 2'b10) ? 7 : 8;
  endfunction

  function automatic logic par_of(input logic [8:0] d, input logic ps);
    return (^d) ^ ps;
  endfunction

  task automatic set_brr(input int unsigned m, input int unsigned f);
    brr.mantissa = 12'(m);
    brr.fraction = 4'(f);
    bitclk = 16 * m + f;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (bitclk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int unsigned nb, input logic usepar,
                            input logic parbit, input logic stopbit);
    drive_bit(1'b0);
    for (int unsigned i = 0; i < nb; i++) drive_bit(d[i]);
    if (usepar) drive_bit(parbit);
    drive_bit(stopbit);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic consume;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clear_all;
    icr = '1;
    @(negedge clk);
    icr = '0;
  endtask

  logic [8:0]  d, mask;
  logic        perr, serr;
  int unsigned nb;

  initial begin
    nchecks = 0; npass = 0;
    rst_n = 1'b0; rxd = 1'b1; rx_ready = 1'b0; icr = '0;
    cr1 = '0; cr1.aue = 1'b1; cr1.re = 1'b1;
    set_brr(54, 4);
    repeat (4) @(negedge clk);
    check("rst_data", 32'(rx_data), 0);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_flags", 32'({pe, fe, ore, idle, busy}), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 at 115200 baud from 100 MHz
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1);
    check("a5_data", 32'(rx_data), 32'h0A5);
    check("a5_valid", 32'(rx_valid), 1);
    check("a5_flags", 32'({pe, fe, ore}), 0);
    consume;
    check("a5_consumed", 32'(rx_valid), 0);

    set_brr(8, 3);
    repeat (2 * bitclk) @(negedge clk);

    // 9-bit odd parity, wrong parity bit
    cr1.wl = 2'b01; cr1.pce = 1'b1; cr1.ps = 1'b1;
    send_frame(9'h1FF, 9, 1'b1, ~par_of(9'h1FF, 1'b1), 1'b1);
    check("pe_data", 32'(rx_data), 32'h1FF);
    check("pe_set", 32'(pe), 1);
    icr.pecf = 1'b1;
    @(negedge clk);
    icr = '0;
    check("pe_clear", 32'(pe), 0);
    consume;
    cr1.wl = 2'b00; cr1.pce = 1'b0; cr1.ps = 1'b0;

    // framing error then a short glitch
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0);
    check("fe_set", 32'(fe), 1);
    check("fe_data", 32'(rx_data), 32'h03C);
    consume;
    icr.fecf = 1'b1;
    @(negedge clk);
    icr = '0;
    check("fe_clear", 32'(fe), 0);
    repeat (bitclk) @(negedge clk);
    rxd = 1'b0;
    repeat (bitclk * 3 / 10) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * bitclk) @(negedge clk);
    check("glitch_busy", 32'(busy), 0);
    check("glitch_valid", 32'(rx_valid), 0);
    check("glitch_flags", 32'({pe, fe, ore}), 0);

    // idle detection and re-arm
    send_frame(9'h055, 8, 1'b0, 1'b0, 1'b1);
    check("idle_data", 32'(rx_data), 32'h055);
    consume;
    repeat (8 * bitclk) @(negedge clk);
    check("idle_early", 32'(idle), 0);
    repeat (3 * bitclk) @(negedge clk);
    check("idle_set", 32'(idle), 1);
    icr.idlecf = 1'b1;
    @(negedge clk);
    icr = '0;
    check("idle_clear", 32'(idle), 0);
    repeat (12 * bitclk) @(negedge clk);
    check("idle_no_rearm", 32'(idle), 0);

    // overrun
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1);
    check("ore_first_valid", 32'(rx_valid), 1);
    check("ore_first_data", 32'(rx_data), 32'h011);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1);
    check("ore_kept_data", 32'(rx_data), 32'h011);
    check("ore_set", 32'(ore), 1);
    consume;
    check("ore_consumed", 32'(rx_valid), 0);
    clear_all;
    check("ore_clear", 32'(ore), 0);

    // receiver disabled mid-frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check("dis_busy_before", 32'(busy), 1);
    cr1.re = 1'b0;
    @(negedge clk);
    check("dis_busy_after", 32'(busy), 0);
    for (int i = 0; i < 6; i++) drive_bit(i[0]);
    drive_bit(1'b1);
    drive_bit(1'b1);
    cr1.re = 1'b1;
    repeat (2 * bitclk) @(negedge clk);
    check("dis_no_commit", 32'(rx_valid), 0);

    // reset in the middle of a frame, with a word still held
    send_frame(9'h077, 8, 1'b0, 1'b0, 1'b1);
    check("pre_rst_valid", 32'(rx_valid), 1);
    drive_bit(1'b0);
    rxd = 1'b1;
    repeat (bitclk / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_data", 32'(rx_data), 0);
    check("mid_rst_valid", 32'(rx_valid), 0);
    check("mid_rst_flags", 32'({pe, fe, ore, idle, busy}), 0);
    repeat (12 * bitclk) @(negedge clk);
    check("mid_rst_idle", 32'(idle), 0);
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1);
    check("post_rst_data", 32'(rx_data), 32'h05A);
    check("post_rst_valid", 32'(rx_valid), 1);
    consume;
    clear_all;

    // randomized frames against the frame-level model
    for (int k = 0; k < 16; k++) begin
      set_brr($urandom_range(7, 3), $urandom_range(15, 0));
      cr1.wl  = 2'($urandom_range(3, 0));
      cr1.pce = 1'($urandom_range(1, 0));
      cr1.ps  = 1'($urandom_range(1, 0));
      nb   = nbits_of(cr1.wl);
      mask = 9'((1 << nb) - 1);
      d    = 9'($urandom_range(511, 0)) & mask;
      perr = ($urandom_range(3, 0) == 0);
      serr = ($urandom_range(4, 0) == 0);
      repeat (bitclk) @(negedge clk);
      send_frame(d, nb, cr1.pce, par_of(d, cr1.ps) ^ perr, ~serr);
      check($sformatf("rnd%0d_data", k), 32'(rx_data), 32'(d));
      check($sformatf("rnd%0d_valid", k), 32'(rx_valid), 1);
      check($sformatf("rnd%0d_pe", k), 32'(pe), 32'(cr1.pce & perr));
      check($sformatf("rnd%0d_fe", k), 32'(fe), 32'(serr));
      check($sformatf("rnd%0d_ore", k), 32'(ore), 0);
      consume;
      clear_all;
    end

    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of rxd synchronizer flops (min 2).
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst_n  input  1  synchronous reset, active-low.
REQ-004 cr1  input  cr1_reg_t  uses aue, re, wl, pce, ps; other fields ignored.
REQ-005 brr  input  brr_reg_t  baud divisor: mantissa + fraction/16 clocks per oversample tick.
REQ-006 icr  input  icr_reg_t  one-cycle clear pulses; uses pecf, fecf, orecf, idlecf.
REQ-007 rxd  input  1  asynchronous serial line, idle high.
REQ-008 rx_data  output  9  received word, LSB-aligned, unused upper bits zero.
REQ-009 rx_valid  output  1  rx_data holds an unread word; also drives the rxne flag.
REQ-010 rx_ready  input  1  downstream accepts rx_data when rx_valid & rx_ready.
REQ-011 pe, fe, ore, idle  output  1 each  sticky status flags.
REQ-012 busy  output  1  high while state != IDLE.

Function
REQ-013 Receiver enabled when cr1.aue & cr1.re; when disabled, state forced to IDLE within one cycle, partial frame discarded, flags and holding register retained.
REQ-014 Baud generator: one-cycle tick every mantissa clocks, plus one extra clock when 4-bit fraction accumulator (acc += fraction) carries; mantissa == 0 suppresses ticks and holds IDLE.
REQ-015 Tick counter 0..15 per bit; data sampled as 2-of-3 majority of ticks 7, 8, 9.
REQ-016 FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE -> START on synchronized falling edge of rxd; tick counter and baud generator reset at that edge.
REQ-018 START: majority at mid-bit must be 0, else false start -> IDLE with no flag change; on valid start, -> DATA at bit end.
REQ-019 Data length: wl 00=8, 01=9, 10=7, 11=8 bits; LSB first; DATA -> PARITY if pce else STOP after last bit.
REQ-020 PARITY: parity bit excluded from rx_data; mismatch sets pe (ps=0 even, ps=1 odd over data + parity).
REQ-021 STOP: only first stop bit checked; sampled 0 sets fe; word committed at stop mid-bit (tick 9), then -> IDLE (enables resync on next start edge at half stop bit).
REQ-022 Commit: if rx_valid = 0, or rx_valid & rx_ready same cycle, load rx_data and set rx_valid next cycle; otherwise new word dropped, old word kept, ore set.
REQ-023 Words with pe/fe still delivered.
REQ-024 rx_valid clears the cycle after handshake unless a commit lands that cycle.
REQ-025 idle sets after rxd high for 10 consecutive bit periods in IDLE following at least one committed frame; re-arms only after the next committed frame.
REQ-026 Clear pulse clears its flag next cycle; set in same cycle as clear wins (flag stays 1).
REQ-027 Output latency: rx_valid rises one clk after the tick-9 stop sample.

Reset
REQ-028 On rst_n = 0: state IDLE, rx_data 0, rx_valid 0, pe/fe/ore/idle 0, busy 0, synchronizer flops 1, tick counter and fraction accumulator 0, idle arm cleared.

Structure
REQ-029 FSM state enum and wl decode constants reside in shared package axilregs_pkg.
REQ-030 Baud/oversample tick generation is sub-module uart_baud_gen (inputs brr, enable, restart; output tick).
REQ-031 Status flag outputs are registers, not combinational.

Verification
REQ-032 brr = {54,4} (100 MHz, 115200 baud), wl=00, pce=0: send 0xA5 -> rx_data=0x0A5, rx_valid=1, no flags.
REQ-033 wl=01, pce=1, ps=1: send 0x1FF with wrong parity bit -> rx_data=0x1FF, pe=1; icr.pecf pulse -> pe=0 next cycle.
REQ-034 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x011, ore=1; rx_ready=1 then -> rx_valid=0.
REQ-035 Stop bit forced 0 on 0x3C -> fe=1, rx_data=0x03C; 0.3-bit low glitch on idle line -> no commit, no flags.
REQ-036 Send one frame then hold rxd high 10 bit periods -> idle=1; cr1.re deasserted mid-frame -> busy=0 next cycle, no commit.
REQ-037 rst_n low mid-frame for one cycle -> all outputs per REQ-028; following frame 0x5A received correctly.
